riscv_id: RTL and testbench

- Instruction-decode stage. Sits directly downstream of the fetch stage and consumes its pipeline registers (instruction, PC, compressed flag, predicted-taken flag).
- Decodes RV32I; compressed instructions arrive already expanded.
- Reads the register file, with write-back bypass; generates immediates and control; detects load-use hazards.
- Registers everything into the ID/EX pipeline registers consumed by the execute stage.

---
 rtl/riscv_pkg.sv | 75 +++++++
 rtl/imm_gen.sv | 34 +++
 rtl/riscv_id.sv | 224 ++++++++++++++++++++++
 tb/tb_riscv_id.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode constants, types and helpers
// Contents: opcode values, ALU operation codes, ALU operand-A select codes,
// immediate format tags, the ID/EX control bundle and the funct3/funct7 to
// ALU-operation mapping.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jal;
        logic       jalr;
    } ctrl_t;

    // allow_sub is 0 for OP-IMM: there bit 30 belongs to the immediate,
    // except for SRAI where it selects the arithmetic shift.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3,
                                                   input logic       funct7_b5,
                                                   input logic       allow_sub);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (allow_sub && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate extractor
// Ports: inst (32-bit instruction) -> imm (sign-extended immediate, 0 when
// the format has none) and imm_type (format tag).
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm,
    output imm_type_e   imm_type
);

    always_comb begin
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_type = IMM_I;
            OPC_STORE:                      imm_type = IMM_S;
            OPC_BRANCH:                     imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC:             imm_type = IMM_U;
            OPC_JAL:                        imm_type = IMM_J;
            default:                        imm_type = IMM_NONE;
        endcase
    end

    always_comb begin
        case (imm_type)
            IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {inst[31:12], 12'b0};
            IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = 32'b0;
        endcase
    end

endmodule

// File: rtl/riscv_id.sv
// rtl/riscv_id.sv - RV32I instruction-decode stage with ID/EX registers
// Ports: fetch inputs (inst_i, pc_i, compressed_i, branch_taken_i), pipeline
// control (stall, flush), register-file read port (rf_rs*_addr/data),
// write-back bypass (wb_reg_write, wb_rd, wb_data), load_use_hazard to fetch,
// and the ID/EX register outputs (*_o) consumed by execute.
module riscv_id
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic                  compressed_i,
    input  logic                  branch_taken_i,
    input  logic                  stall,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] rf_rs1_addr,
    output logic [REG_ADDR_W-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]       rf_rs1_data,
    input  logic [XLEN-1:0]       rf_rs2_data,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  load_use_hazard,
    output logic [XLEN-1:0]       pc_o,
    output logic [XLEN-1:0]       rs1_data_o,
    output logic [XLEN-1:0]       rs2_data_o,
    output logic [XLEN-1:0]       imm_o,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [REG_ADDR_W-1:0] rs2_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [2:0]            funct3_o,
    output logic [3:0]            alu_op_o,
    output logic [1:0]            alu_src_a_o,
    output logic                  alu_src_b_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic                  branch_o,
    output logic                  jal_o,
    output logic                  jalr_o,
    output logic                  compressed_o,
    output logic                  branch_taken_o,
    output logic                  illegal_o
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    imm_type_e             imm_type;

    ctrl_t                 ctrl;
    ctrl_t                 ctrl_q;
    logic                  uses_rs1;
    logic                  uses_rs2;
    logic                  writes_rd;
    logic                  illegal;
    logic [REG_ADDR_W-1:0] rd_d;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign rd     = inst_i[11:7];

    assign rf_rs1_addr = rs1;
    assign rf_rs2_addr = rs2;

    imm_gen u_imm_gen (
        .inst     (inst_i),
        .imm      (imm),
        .imm_type (imm_type)
    );

    always_comb begin
        ctrl      = '0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LUI: begin
                    ctrl.alu_src_a = SRC_A_ZERO;
                    writes_rd      = 1'b1;
                end
                OPC_AUIPC: begin
                    ctrl.alu_src_a = SRC_A_PC;
                    writes_rd      = 1'b1;
                end
                OPC_JAL: begin
                    ctrl.alu_src_a = SRC_A_PC;
                    ctrl.jal       = 1'b1;
                    writes_rd      = 1'b1;
                end
                OPC_JALR: begin
                    ctrl.jalr = 1'b1;
                    uses_rs1  = 1'b1;
                    writes_rd = 1'b1;
                end
                OPC_BRANCH: begin
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALU_SUB;
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                end
                OPC_LOAD: begin
                    ctrl.mem_read   = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    uses_rs1        = 1'b1;
                    writes_rd       = 1'b1;
                end
                OPC_STORE: begin
                    ctrl.mem_write = 1'b1;
                    uses_rs1       = 1'b1;
                    uses_rs2       = 1'b1;
                end
                OPC_OP_IMM: begin
                    ctrl.alu_op = alu_from_funct(funct3, inst_i[30], 1'b0);
                    uses_rs1    = 1'b1;
                    writes_rd   = 1'b1;
                end
                OPC_OP: begin
                    ctrl.alu_op = alu_from_funct(funct3, inst_i[30], 1'b1);
                    uses_rs1    = 1'b1;
                    uses_rs2    = 1'b1;
                    writes_rd   = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
        // Every format that carries an immediate except B feeds it to the ALU;
        // branches compare rs1 against rs2.
        ctrl.alu_src_b = (imm_type == IMM_I) || (imm_type == IMM_S) ||
                         (imm_type == IMM_U) || (imm_type == IMM_J);
        ctrl.reg_write = writes_rd && (rd != '0);
        // Non-writing instructions carry rd = 0 so forwarding never matches them.
        rd_d = writes_rd ? rd : '0;
    end

    // Write-back bypass: the register file returns the old value in the same
    // cycle it is written, so the write-back value takes precedence.
    always_comb begin
        if (rs1 == '0)
            rs1_data = '0;
        else if (wb_reg_write && wb_rd == rs1)
            rs1_data = wb_data;
        else
            rs1_data = rf_rs1_data;

        if (rs2 == '0)
            rs2_data = '0;
        else if (wb_reg_write && wb_rd == rs2)
            rs2_data = wb_data;
        else
            rs2_data = rf_rs2_data;
    end

    assign load_use_hazard = !flush && ctrl_q.mem_read && (rd_o != '0) &&
                             ((uses_rs1 && rs1 == rd_o) || (uses_rs2 && rs2 == rd_o));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_o           <= '0;
            rs1_data_o     <= '0;
            rs2_data_o     <= '0;
            imm_o          <= '0;
            rs1_o          <= '0;
            rs2_o          <= '0;
            rd_o           <= '0;
            funct3_o       <= '0;
            ctrl_q         <= '0;
            compressed_o   <= 1'b0;
            branch_taken_o <= 1'b0;
            illegal_o      <= 1'b0;
        end else if (!stall) begin
            pc_o       <= pc_i;
            rs1_data_o <= rs1_data;
            rs2_data_o <= rs2_data;
            imm_o      <= imm;
            rs1_o      <= rs1;
            rs2_o      <= rs2;
            funct3_o   <= funct3;
            if (flush || load_use_hazard) begin
                ctrl_q         <= '0;
                rd_o           <= '0;
                compressed_o   <= 1'b0;
                branch_taken_o <= 1'b0;
                illegal_o      <= 1'b0;
            end else begin
                // An illegal instruction is already a zero-control bubble; only
                // the illegal flag survives.
                ctrl_q         <= ctrl;
                rd_o           <= rd_d;
                compressed_o   <= compressed_i && !illegal;
                branch_taken_o <= branch_taken_i && !illegal;
                illegal_o      <= illegal;
            end
        end
    end

    assign alu_op_o     = ctrl_q.alu_op;
    assign alu_src_a_o  = ctrl_q.alu_src_a;
    assign alu_src_b_o  = ctrl_q.alu_src_b;
    assign mem_read_o   = ctrl_q.mem_read;
    assign mem_write_o  = ctrl_q.mem_write;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign branch_o     = ctrl_q.branch;
    assign jal_o        = ctrl_q.jal;
    assign jalr_o       = ctrl_q.jalr;

endmodule

// File: tb/tb_riscv_id.sv
// tb/tb_riscv_id.sv - directed table-driven bench for riscv_id
module tb_riscv_id;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst_i, pc_i;
    logic        compressed_i, branch_taken_i, stall, flush;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        load_use_hazard;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic [2:0]  funct3_o;
    logic [3:0]  alu_op_o;
    logic [1:0]  alu_src_a_o;
    logic        alu_src_b_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o;
    logic        branch_o, jal_o, jalr_o, compressed_o, branch_taken_o, illegal_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_id dut (
        .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .pc_i(pc_i),
        .compressed_i(compressed_i), .branch_taken_i(branch_taken_i),
        .stall(stall), .flush(flush),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .load_use_hazard(load_use_hazard),
        .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .funct3_o(funct3_o),
        .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
        .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o), .jal_o(jal_o), .jalr_o(jalr_o),
        .compressed_o(compressed_o), .branch_taken_o(branch_taken_o), .illegal_o(illegal_o)
    );

    // ctl = {mem_read, mem_write, reg_write, mem_to_reg, branch, jal, jalr}
    typedef struct {
        logic [31:0] inst, pc, rf1, rf2;
        logic        wbw;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        comp, bt;
        logic [31:0] e_imm, e_rs1d, e_rs2d;
        logic [4:0]  e_rd;
        logic [3:0]  e_alu;
        logic [1:0]  e_srca;
        logic        e_srcb;
        logic [6:0]  e_ctl;
        logic        e_ill, e_comp, e_bt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, branch_o, jal_o, jalr_o};
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        inst_i = inst; pc_i = pc;
        compressed_i = 1'b0; branch_taken_i = 1'b0;
        rf_rs1_data = 32'h0; rf_rs2_data = 32'h0;
        wb_reg_write = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF00293, 32'h100, 32'h55, 32'h66, 0, 0, 0, 0, 0,
                     32'hFFFFFFFF, 32'h0, 32'h66, 5, ALU_ADD, SRC_A_RS1, 1, 7'b0010000, 0, 0, 0};
        vecs[1]  = '{32'h00018233, 32'h104, 32'h0, 32'h9, 1, 3, 32'hDEADBEEF, 0, 0,
                     32'h0, 32'hDEADBEEF, 32'h0, 4, ALU_ADD, SRC_A_RS1, 0, 7'b0010000, 0, 0, 0};
        vecs[2]  = '{32'h00018233, 32'h108, 32'h0, 32'h9, 1, 0, 32'hDEADBEEF, 0, 0,
                     32'h0, 32'h0, 32'h0, 4, ALU_ADD, SRC_A_RS1, 0, 7'b0010000, 0, 0, 0};
        vecs[3]  = '{32'h403100B3, 32'h200, 32'h11, 32'h22, 0, 0, 0, 0, 0,
                     32'h0, 32'h11, 32'h22, 1, ALU_SUB, SRC_A_RS1, 0, 7'b0010000, 0, 0, 0};
        vecs[4]  = '{32'h4033D313, 32'h204, 32'h77, 32'h33, 0, 0, 0, 0, 0,
                     32'h403, 32'h77, 32'h33, 6, ALU_SRA, SRC_A_RS1, 1, 7'b0010000, 0, 0, 0};
        vecs[5]  = '{32'h12345537, 32'h208, 32'hAAAA, 32'hBBBB, 0, 0, 0, 0, 0,
                     32'h12345000, 32'hAAAA, 32'hBBBB, 10, ALU_ADD, SRC_A_ZERO, 1, 7'b0010000, 0, 0, 0};
        vecs[6]  = '{32'h00001097, 32'h400, 32'h5, 32'h6, 0, 0, 0, 0, 0,
                     32'h1000, 32'h0, 32'h0, 1, ALU_ADD, SRC_A_PC, 1, 7'b0010000, 0, 0, 0};
        vecs[7]  = '{32'h0020A423, 32'h404, 32'h1000, 32'h2000, 0, 0, 0, 0, 0,
                     32'h8, 32'h1000, 32'h2000, 0, ALU_ADD, SRC_A_RS1, 1, 7'b0100000, 0, 0, 0};
        vecs[8]  = '{32'hFE208EE3, 32'h408, 32'h3, 32'h4, 0, 0, 0, 0, 1,
                     32'hFFFFFFFC, 32'h3, 32'h4, 0, ALU_SUB, SRC_A_RS1, 0, 7'b0000100, 0, 0, 1};
        vecs[9]  = '{32'h008000EF, 32'h40C, 32'h7, 32'h8, 0, 0, 0, 1, 0,
                     32'h8, 32'h0, 32'h8, 1, ALU_ADD, SRC_A_PC, 1, 7'b0010010, 0, 1, 0};
        vecs[10] = '{32'h00008067, 32'h410, 32'h44, 32'h8, 0, 0, 0, 0, 0,
                     32'h0, 32'h44, 32'h0, 0, ALU_ADD, SRC_A_RS1, 1, 7'b0000001, 0, 0, 0};
        vecs[11] = '{32'h0000007F, 32'h414, 32'h1, 32'h2, 0, 0, 0, 1, 1,
                     32'h0, 32'h0, 32'h0, 0, 4'd0, 2'd0, 0, 7'b0000000, 1, 0, 0};
        vecs[12] = '{32'h00208033, 32'h418, 32'h5, 32'h6, 0, 0, 0, 0, 0,
                     32'h0, 32'h5, 32'h6, 0, ALU_ADD, SRC_A_RS1, 0, 7'b0000000, 0, 0, 0};
        vecs[13] = '{32'h00000001, 32'h41C, 32'h1, 32'h2, 0, 0, 0, 0, 1,
                     32'h0, 32'h0, 32'h0, 0, 4'd0, 2'd0, 0, 7'b0000000, 1, 0, 0};
        vecs[14] = '{32'h00518233, 32'h420, 32'h33, 32'h0, 1, 5, 32'hCAFEF00D, 0, 0,
                     32'h0, 32'h33, 32'hCAFEF00D, 4, ALU_ADD, SRC_A_RS1, 0, 7'b0010000, 0, 0, 0};
        vecs[15] = '{32'h0F04F413, 32'h424, 32'h99, 32'h10, 0, 0, 0, 0, 0,
                     32'hF0, 32'h99, 32'h10, 8, ALU_AND, SRC_A_RS1, 1, 7'b0010000, 0, 0, 0};

        // Reset state
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(NOP, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset pc_o", pc_o, 32'h0);
        chk("reset ctl", {25'b0, ctl_now()}, 32'h0);
        chk("reset rd_o", {27'b0, rd_o}, 32'h0);
        chk("reset hazard", {31'b0, load_use_hazard}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single instructions
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].inst, vecs[i].pc);
            rf_rs1_data = vecs[i].rf1; rf_rs2_data = vecs[i].rf2;
            wb_reg_write = vecs[i].wbw; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
            compressed_i = vecs[i].comp; branch_taken_i = vecs[i].bt;
            after_edge();
            chk($sformatf("v%0d imm", i), imm_o, vecs[i].e_imm);
            chk($sformatf("v%0d pc", i), pc_o, vecs[i].pc);
            chk($sformatf("v%0d rs1d", i), rs1_data_o, vecs[i].e_rs1d);
            chk($sformatf("v%0d rs2d", i), rs2_data_o, vecs[i].e_rs2d);
            chk($sformatf("v%0d rd", i), {27'b0, rd_o}, {27'b0, vecs[i].e_rd});
            chk($sformatf("v%0d alu", i), {28'b0, alu_op_o}, {28'b0, vecs[i].e_alu});
            chk($sformatf("v%0d srca", i), {30'b0, alu_src_a_o}, {30'b0, vecs[i].e_srca});
            chk($sformatf("v%0d srcb", i), {31'b0, alu_src_b_o}, {31'b0, vecs[i].e_srcb});
            chk($sformatf("v%0d ctl", i), {25'b0, ctl_now()}, {25'b0, vecs[i].e_ctl});
            chk($sformatf("v%0d flags", i), {29'b0, illegal_o, compressed_o, branch_taken_o},
                {29'b0, vecs[i].e_ill, vecs[i].e_comp, vecs[i].e_bt});
        end

        // Stall holds ANDI x8 for three cycles
        @(negedge clk);
        drive(32'h403100B3, 32'h500);
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            after_edge();
            chk($sformatf("stall%0d rd", c), {27'b0, rd_o}, 32'd8);
            chk($sformatf("stall%0d pc", c), pc_o, 32'h424);
            chk($sformatf("stall%0d alu", c), {28'b0, alu_op_o}, {28'b0, ALU_AND});
        end
        @(negedge clk);
        stall = 1'b0;

        // Load-use: LW x6,0(x1) then ADD x7,x6,x2
        drive(32'h0000A303, 32'h600);
        after_edge();
        chk("lw mem_read", {31'b0, mem_read_o}, 32'h1);
        chk("lw rd", {27'b0, rd_o}, 32'd6);
        @(negedge clk);
        drive(32'h002303B3, 32'h604);
        #1 chk("lu hazard", {31'b0, load_use_hazard}, 32'h1);
        after_edge();
        chk("lu bubble ctl", {25'b0, ctl_now()}, 32'h0);
        chk("lu bubble rd", {27'b0, rd_o}, 32'h0);
        chk("lu hazard cleared", {31'b0, load_use_hazard}, 32'h0);
        after_edge();
        chk("lu add rs1", {27'b0, rs1_o}, 32'd6);
        chk("lu add rd", {27'b0, rd_o}, 32'd7);
        chk("lu add reg_write", {31'b0, reg_write_o}, 32'h1);

        // Stall and hazard together: stall wins, hazard stays asserted
        @(negedge clk);
        drive(32'h0000A303, 32'h700);
        after_edge();
        @(negedge clk);
        drive(32'h002303B3, 32'h704);
        stall = 1'b1;
        #1 chk("st+lu hazard", {31'b0, load_use_hazard}, 32'h1);
        after_edge();
        chk("st+lu hold mem_read", {31'b0, mem_read_o}, 32'h1);
        chk("st+lu hold rd", {27'b0, rd_o}, 32'd6);
        chk("st+lu hazard kept", {31'b0, load_use_hazard}, 32'h1);

        // Flush masks the hazard and loads a bubble
        @(negedge clk);
        stall = 1'b0; flush = 1'b1;
        #1 chk("flush masks hazard", {31'b0, load_use_hazard}, 32'h0);
        after_edge();
        chk("flush bubble ctl", {25'b0, ctl_now()}, 32'h0);
        chk("flush bubble rd", {27'b0, rd_o}, 32'h0);

        // Flushed SW: first unflushed for contrast
        @(negedge clk);
        flush = 1'b0;
        drive(32'h0020A423, 32'h800);
        after_edge();
        chk("sw mem_write", {31'b0, mem_write_o}, 32'h1);
        @(negedge clk);
        flush = 1'b1;
        after_edge();
        chk("sw flushed mem_write", {31'b0, mem_write_o}, 32'h0);
        chk("sw flushed rd", {27'b0, rd_o}, 32'h0);
        @(negedge clk);
        flush = 1'b0;

        // Asynchronous reset mid-cycle
        drive(32'hFFF00293, 32'h900);
        after_edge();
        chk("pre-reset reg_write", {31'b0, reg_write_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset pc", pc_o, 32'h0);
        chk("async reset imm", imm_o, 32'h0);
        chk("async reset ctl", {25'b0, ctl_now()}, 32'h0);
        chk("async reset rd", {27'b0, rd_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        after_edge();
        chk("post-reset imm", imm_o, 32'hFFFFFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
